instruction_prefetch_queue: RTL and testbench

//   Fetch stage feeding the issue register. Reads sequential instruction words

---
 rtl/instruction_prefetch_queue.sv | 103 ++++++++++
 tb/tb_instruction_prefetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch from memory port 0 into a DEPTH-entry
// {pc, instr} FIFO with valid/ready issue port. Optional: PREFETCH_JUMP_HALT_EN.
module instruction_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AW        = 2,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [4:0]  JUMP_TYPE = 5'd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_addr,
    output logic          imem_req,
    output logic [31:0]   imem_raddr,
    input  logic [31:0]   imem_rdata,
    output logic          issue_valid,
    output logic [31:0]   issue_instr,
    output logic [31:0]   issue_pc,
    input  logic          issue_ready,
    output logic [AW:0]   occupancy
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          halted_q, halted_d;
    logic          head_valid, push, pop, halt_hit;

    assign head_valid = (count_q != '0);
    assign pop        = head_valid & issue_ready & ~redirect_valid;
    // rst gates push so every output except the fetch address reads 0 while in reset
    assign push       = rst & ~redirect_valid & ~halted_q & ((count_q != FULL_CNT) | pop);

`ifdef PREFETCH_JUMP_HALT_EN
    assign halt_hit = push & (imem_rdata[31:27] == JUMP_TYPE);
`else
    logic unused_jump_type;
    assign unused_jump_type = ^JUMP_TYPE;
    assign halt_hit = 1'b0;
`endif

    assign imem_req    = push;
    assign imem_raddr  = fetch_pc_q;
    assign issue_valid = head_valid;
    assign issue_pc    = head_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign issue_instr = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign occupancy   = count_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        if (redirect_valid) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_addr;
            halted_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd1;
                halted_d   = halted_q | halt_hit;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Self-checking bench for instruction_prefetch_queue: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_instruction_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        issue_ready;
    logic [AW:0] occupancy;

    logic        jump_en;
    logic [31:0] jump_addr;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_prefetch_queue #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .RESET_PC  (32'h0),
        .JUMP_TYPE (5'd31)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_raddr     (imem_raddr),
        .imem_rdata     (imem_rdata),
        .issue_valid    (issue_valid),
        .issue_instr    (issue_instr),
        .issue_pc       (issue_pc),
        .issue_ready    (issue_ready),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (jump_en && a == jump_addr) return {5'd31, a[26:0]};
        return a + 32'd100;
    endfunction

    always_comb imem_rdata = memf(imem_raddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [31:0] m_pc[$];
    logic [31:0] m_ins[$];
    logic [31:0] m_fetch = 32'h0;
    bit          m_halted = 1'b0;

    function automatic bit m_pop();
        return (m_pc.size() != 0) && issue_ready && !redirect_valid;
    endfunction

    function automatic bit m_push();
        return rst && !redirect_valid && !m_halted && (m_pc.size() < DEPTH || m_pop());
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc.delete(); m_ins.delete();
            m_fetch  = 32'h0;
            m_halted = 1'b0;
        end else if (redirect_valid) begin
            m_pc.delete(); m_ins.delete();
            m_fetch  = redirect_addr;
            m_halted = 1'b0;
        end else begin
            bit pu, po;
            logic [31:0] w;
            pu = m_push();
            po = m_pop();
            if (po) begin
                void'(m_pc.pop_front());
                void'(m_ins.pop_front());
            end
            if (pu) begin
                w = memf(m_fetch);
                m_pc.push_back(m_fetch);
                m_ins.push_back(w);
`ifdef PREFETCH_JUMP_HALT_EN
                if (w[31:27] == 5'd31) m_halted = 1'b1;
`endif
                m_fetch = m_fetch + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_valid", 32'(issue_valid), 32'd0);
            check("rst_instr", issue_instr, 32'd0);
            check("rst_pc",    issue_pc, 32'd0);
            check("rst_occ",   32'(occupancy), 32'd0);
            check("rst_req",   32'(imem_req), 32'd0);
            check("rst_raddr", imem_raddr, 32'h0);
        end else begin
            bit v;
            v = (m_pc.size() != 0);
            check("cyc_valid", 32'(issue_valid), 32'(v));
            check("cyc_instr", issue_instr, v ? m_ins[0] : 32'd0);
            check("cyc_pc",    issue_pc,    v ? m_pc[0]  : 32'd0);
            check("cyc_occ",   32'(occupancy), 32'(m_pc.size()));
            check("cyc_req",   32'(imem_req), 32'(m_push()));
            check("cyc_raddr", imem_raddr, m_fetch);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        issue_ready = 1'b1; jump_en = 1'b0; jump_addr = 32'd2;

        // Reset state
        repeat (2) step();
        check("lit_reset_raddr", imem_raddr, 32'h0);
        check("lit_reset_valid", 32'(issue_valid), 32'd0);
        check("lit_reset_req",   32'(imem_req), 32'd0);

        // 1: streaming, one per cycle
        rst = 1'b1;
        step();
        check("lit_t1_pc0",    issue_pc, 32'd0);
        check("lit_t1_ins0",   issue_instr, 32'd100);
        check("lit_t1_occ",    32'(occupancy), 32'd1);
        step();
        check("lit_t1_ins1",   issue_instr, 32'd101);
        step();
        check("lit_t1_ins2",   issue_instr, 32'd102);

        // 5: async reset between edges
        #1;
        rst = 1'b0;
        #1;
        check("lit_t5_valid",  32'(issue_valid), 32'd0);
        check("lit_t5_occ",    32'(occupancy), 32'd0);
        check("lit_t5_raddr",  imem_raddr, 32'h0);
        issue_ready = 1'b0;
        step(); step();
        rst = 1'b1;

        // 2: stall fills the queue
        repeat (8) step();
        check("lit_t2_occ",    32'(occupancy), 32'd4);
        check("lit_t2_req",    32'(imem_req), 32'd0);
        check("lit_t2_pc",     issue_pc, 32'd0);
        check("lit_t2_ins",    issue_instr, 32'd100);

        // 3: full queue drains with push and pop together
        issue_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("lit_t3_pc",  issue_pc, 32'(k));
            check("lit_t3_occ", 32'(occupancy), 32'd4);
        end

        // 4: redirect with 3 entries queued
        redirect_valid = 1'b1; redirect_addr = 32'h20; issue_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        check("lit_t4_occ3",   32'(occupancy), 32'd3);
        redirect_valid = 1'b1; redirect_addr = 32'h40;
        step();
        redirect_valid = 1'b0; issue_ready = 1'b1;
        check("lit_t4_valid",  32'(issue_valid), 32'd0);
        check("lit_t4_occ0",   32'(occupancy), 32'd0);
        check("lit_t4_raddr",  imem_raddr, 32'h40);
        step();
        check("lit_t4_pc",     issue_pc, 32'h40);
        check("lit_t4_ins",    issue_instr, 32'hA4);

        // 6: jump word at pc 2
        jump_en = 1'b1; jump_addr = 32'd2;
        redirect_valid = 1'b1; redirect_addr = 32'h0; issue_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        check("lit_t6_occ3",   32'(occupancy), 32'd3);
        check("lit_t6_raddr",  imem_raddr, 32'd3);
`ifdef PREFETCH_JUMP_HALT_EN
        check("lit_t6_req",    32'(imem_req), 32'd0);
`else
        check("lit_t6_req",    32'(imem_req), 32'd1);
`endif
        step(); step();
`ifdef PREFETCH_JUMP_HALT_EN
        check("lit_t6_hold",   32'(occupancy), 32'd3);
`else
        check("lit_t6_hold",   32'(occupancy), 32'd4);
`endif
        issue_ready = 1'b1;
        check("lit_t6_pc0",    issue_pc, 32'd0);
        step();
        check("lit_t6_pc1",    issue_pc, 32'd1);
        step();
        check("lit_t6_pc2",    issue_pc, 32'd2);
        check("lit_t6_jump",   issue_instr, 32'hF800_0002);
        step();
`ifdef PREFETCH_JUMP_HALT_EN
        check("lit_t6_empty",  32'(issue_valid), 32'd0);
`else
        check("lit_t6_pc3",    issue_instr, 32'd103);
`endif
        redirect_valid = 1'b1; redirect_addr = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        check("lit_t6_resume", issue_pc, 32'h10);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
